// File: rtl/can_clic_nested_pkg.sv
// Shared sizes, types and per-source configuration record for the nested CLIC.
package can_clic_nested_pkg;

  localparam int unsigned N_SRC   = 8;
  localparam int unsigned PRIO_W  = 3;
  localparam int unsigned NEST    = 4;
  localparam int unsigned IDX_W   = $clog2(N_SRC);
  localparam int unsigned DEPTH_W = $clog2(NEST + 1);
  localparam int unsigned STK_W   = $clog2(NEST);

  typedef logic [PRIO_W-1:0]  prio_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [DEPTH_W-1:0] depth_t;
  typedef logic [STK_W-1:0]   stk_idx_t;

  typedef struct packed {
    prio_t prio;
    logic  en;
    logic  edge_trig;
  } src_cfg_t;

endpackage

// File: rtl/can_clic_nested_tree.sv
// Combinational max-priority selection over all requesting sources; ties resolve to the lowest index.
module can_clic_nested_tree
  import can_clic_nested_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  prio_t            prio [N_SRC],
  output logic             win_valid_c,
  output idx_t             win_idx_c,
  output prio_t            win_prio_c
);

  // Ascending scan with strict compare keeps the lowest index on equal priority.
  always_comb begin
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    win_prio_c  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i] && (!win_valid_c || (prio[i] > win_prio_c))) begin
        win_valid_c = 1'b1;
        win_idx_c   = IDX_W'(i);
        win_prio_c  = prio[i];
      end
    end
  end

endmodule

// File: rtl/can_clic_nested.sv
// Clocked CLIC: pending/config state, threshold stack for nested preemption, registered request to the core.
module can_clic_nested
  import can_clic_nested_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   src_i,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [PRIO_W-1:0]  cfg_prio,
  input  logic               cfg_en,
  input  logic               cfg_edge,
  input  logic               thr_we,
  input  logic [PRIO_W-1:0]  thr_val,
  output logic               irq_valid,
  output logic [IDX_W-1:0]   irq_id,
  output logic [PRIO_W-1:0]  irq_prio,
  input  logic               irq_ready,
  input  logic               complete,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_underflow
);

  src_cfg_t         cfg_q   [N_SRC];
  prio_t            stack_q [NEST];
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend_q;
  prio_t            base_thr_q;

  logic [N_SRC-1:0] req_c;
  prio_t            prio_c [N_SRC];
  logic             win_valid_c;
  idx_t             win_idx_c;
  prio_t            win_prio_c;

  logic             claim_c;
  logic             nested_c;
  logic             full_c;
  logic [N_SRC-1:0] claim_clr_c;
  stk_idx_t         top_idx_c;
  stk_idx_t         push_idx_c;
  prio_t            cur_thr_c;
  logic             cand_c;

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      req_c[i]  = pend_q[i] & cfg_q[i].en;
      prio_c[i] = cfg_q[i].prio;
    end
  end

  can_clic_nested_tree u_tree (
    .req         (req_c),
    .prio        (prio_c),
    .win_valid_c (win_valid_c),
    .win_idx_c   (win_idx_c),
    .win_prio_c  (win_prio_c)
  );

  // Active threshold is the stack top while nested, otherwise the software base.
  always_comb begin
    claim_c     = irq_valid & irq_ready;
    nested_c    = (depth != '0);
    full_c      = (depth >= DEPTH_W'(NEST));
    top_idx_c   = STK_W'(depth - depth_t'(1));
    push_idx_c  = STK_W'(depth);
    claim_clr_c = claim_c ? (N_SRC'(1) << irq_id) : '0;
    cur_thr_c   = nested_c ? stack_q[top_idx_c] : base_thr_q;
    cand_c      = win_valid_c && (win_prio_c > cur_thr_c) && !full_c && !claim_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q         <= '0;
      pend_q        <= '0;
      base_thr_q    <= '0;
      depth         <= '0;
      irq_valid     <= 1'b0;
      irq_id        <= '0;
      irq_prio      <= '0;
      err_underflow <= 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) cfg_q[i] <= '0;
      for (int unsigned i = 0; i < NEST; i++) stack_q[i] <= '0;
    end else begin
      src_q <= src_i;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (cfg_q[i].edge_trig) pend_q[i] <= (pend_q[i] & ~claim_clr_c[i]) | (src_i[i] & ~src_q[i]);
        else                    pend_q[i] <= src_i[i];
      end

      if (cfg_we && (32'(cfg_idx) < N_SRC))
        cfg_q[cfg_idx] <= '{prio: cfg_prio, en: cfg_en, edge_trig: cfg_edge};
      if (thr_we) base_thr_q <= thr_val;

      // Tail-chain replaces the top in place; otherwise claim pushes and complete pops.
      if (claim_c) begin
        if (complete && nested_c) begin
          stack_q[top_idx_c] <= irq_prio;
        end else if (!full_c) begin
          stack_q[push_idx_c] <= irq_prio;
          depth               <= depth + depth_t'(1);
        end
      end else if (complete && nested_c) begin
        depth <= depth - depth_t'(1);
      end

      err_underflow <= complete && !claim_c && !nested_c;
      irq_valid     <= cand_c;
      irq_id        <= cand_c ? win_idx_c  : '0;
      irq_prio      <= cand_c ? win_prio_c : '0;
    end
  end

endmodule
